// File: rtl/sd_block_reader.sv
// sd_block_reader: block-read sequencer in front of the SD-card helper.
// A command (lba, nblocks) produces one set-address pulse followed by
// back-to-back read strobes. Each returned word lands in a small FIFO that
// is presented to the consumer as a valid/ready stream.
//
// Handshakes: cmd_valid/cmd_ready and out_valid/out_ready both transfer on
// a posedge where valid and ready are high together. Valid never depends on
// ready, and out_data holds steady while out_valid is high and out_ready low.
module sd_block_reader #(
    parameter int FIFO_DEPTH      = 8,
    parameter int WORDS_PER_BLOCK = 128
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_lba,
    input  logic [15:0] cmd_nblocks,
    input  logic        abort,
    output logic        sd_setAddr,
    output logic [31:0] sd_addr,
    output logic        sd_ren,
    input  logic [31:0] sd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done,
    output logic        aborted
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETADDR = 3'd1,
        S_READ    = 3'd2,
        S_DRAIN   = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] lba_q, lba_d;
    logic [22:0] remaining_q, remaining_d;
    logic        aborted_q, aborted_d;

    logic [31:0] mem_q [FIFO_DEPTH];
    logic [31:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic        in_xfer;
    logic        abort_hit;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic [22:0] total_words;

    // Status decode from the registered state.
    always_comb begin
        in_xfer     = (state_q == S_SETADDR) || (state_q == S_READ) || (state_q == S_DRAIN);
        abort_hit   = abort && in_xfer;
        fifo_full   = (count_q == CW'(FIFO_DEPTH));
        // Write credit comes only from the registered count: a pop in the
        // same cycle does not free a slot for this cycle's read.
        sd_ren      = (state_q == S_READ) && !fifo_full && !abort;
        push        = sd_ren;
        pop         = out_valid && out_ready;
        total_words = 23'(cmd_nblocks) * 23'(WORDS_PER_BLOCK);
    end

    // Output decode; everything comes straight off flops except sd_ren.
    always_comb begin
        cmd_ready  = (state_q == S_IDLE);
        busy       = in_xfer;
        done       = (state_q == S_FIN);
        aborted    = (state_q == S_FIN) && aborted_q;
        sd_setAddr = (state_q == S_SETADDR);
        sd_addr    = lba_q;
        out_valid  = (count_q != '0);
        out_data   = mem_q[rd_ptr_q];
    end

    // Sequencer next-state: command latch, word countdown, abort capture.
    always_comb begin
        state_d     = state_q;
        lba_d       = lba_q;
        remaining_d = remaining_q;
        aborted_d   = aborted_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    lba_d       = cmd_lba;
                    remaining_d = total_words;
                    aborted_d   = 1'b0;
                    state_d     = (cmd_nblocks == 16'd0) ? S_FIN : S_SETADDR;
                end
            end
            S_SETADDR: begin
                if (abort_hit) begin
                    aborted_d = 1'b1;
                    state_d   = S_FIN;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (abort_hit) begin
                    aborted_d = 1'b1;
                    state_d   = S_FIN;
                end else if (sd_ren) begin
                    remaining_d = remaining_q - 23'd1;
                    if (remaining_q == 23'd1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (abort_hit) begin
                    aborted_d = 1'b1;
                    state_d   = S_FIN;
                end else if (count_q == '0) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO next-state: push on each read strobe, pop on handshake, flush on abort.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (abort_hit) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = sd_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            lba_q       <= '0;
            remaining_q <= '0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lba_q       <= lba_d;
            remaining_q <= remaining_d;
            aborted_q   <= aborted_d;
        end
    end

    // FIFO storage and pointers; storage is cleared so out_data reads 0 after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
